hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage datapath.
- Drives every latch-control input of the stage latches: pc_en, pipe1_en..pipe4_en, hz_flushed1, hz_flushed2 and flushed.
- Uses hazard information read back from the latch outputs.
- Sequences load-use stalls, data-memory waits, taken-branch/jump flushes and the halt drain. Owns the only halt-state FSM in the core.

Parameters:
- DRAIN_CYCLES, 2: cycles spent in HALT_DRAIN after halt reaches MEM, before halt is asserted.
- CNT_W, 32: width of the optional stall counter.

Ports:
- CLK  in  1  core clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- d_ren_o2  in  1  EX-stage instruction is a load
- wsel_o2  in  5  EX-stage destination register (regbits_t)
- rsel1_i2  in  5  DEC-stage source register 1
- rsel2_i2  in  5  DEC-stage source register 2
- d_ren_o3  in  1  MEM-stage load request
- d_wen_o3  in  1  MEM-stage store request
- redirect_o3  in  1  MEM-stage branch taken, jump or jr (PC redirect)
- halt_o3  in  1  halt instruction in MEM
- pc_en  out  1  PC register update enable
- pipe1_en  out  1  IF/DC latch enable
- pipe2_en  out  1  DC/EX latch enable
- pipe3_en  out  1  EX/MEM latch enable
- pipe4_en  out  1  MEM/WB latch enable
- hz_flushed1  out  1  load NOP into IF/DC when pipe1_en=1
- hz_flushed2  out  1  load NOP into DC/EX when pipe2_en=1
- flushed  out  1  load NOP into EX/MEM when pipe3_en=1
- halt  out  1  core halted (registered)
- stall_cnt  out  CNT_W  stall-cycle count (only with feature)

Behaviour:
- Reset: async on nRST low.
  - State <= RUN, drain counter <= 0, halt <= 0, stall_cnt <= 0.
  - While nRST=0, all enables and flush outputs are 0.
- Outputs: combinational from state and inputs, except halt, which is registered.
- Condition terms:
  - mem_busy = (d_ren_o3 | d_wen_o3) & ~dhit
  - load_use = d_ren_o2 & (wsel_o2 != 0) & (wsel_o2 == rsel1_i2 | wsel_o2 == rsel2_i2)
- FSM states: RUN, HALT_DRAIN, HALTED.
- RUN, checks in strict priority order:
  1. mem_busy: all five enables 0, no flush. Holds until dhit; in the dhit cycle the pipeline advances normally.
  2. halt_o3 (and not mem_busy):
     - pc_en=0; pipe1_en=pipe2_en=pipe3_en=1 with hz_flushed1=hz_flushed2=flushed=1; pipe4_en=1.
     - Counter <= 0. Next state HALT_DRAIN.
  3. redirect_o3:
     - pc_en=1; all four pipe enables 1.
     - hz_flushed1=hz_flushed2=flushed=1, which kills the 3 younger instructions.
     - Overrides load_use and ihit=0. PC must still load the target even if ihit=0.
  4. load_use:
     - pc_en=0, pipe1_en=0.
     - pipe2_en=1 with hz_flushed2=1 (bubble into EX).
     - pipe3_en=pipe4_en=1.
     - Exactly one bubble per load-use pair, because the load moves to MEM next cycle.
  5. ~ihit:
     - pc_en=0; pipe1_en=1 with hz_flushed1=1 (bubble into DC).
     - pipe2..4_en=1.
  6. Otherwise: all enables 1, no flushes.
- HALT_DRAIN:
  - pc_en=0 and flush outputs 1 with pipe1..3_en=1, so no new work enters.
  - pipe4_en=1, unless mem_busy, which freezes everything including the counter.
  - Counter increments each non-frozen cycle.
  - When counter == DRAIN_CYCLES-1: next state HALTED, halt <= 1.
- HALTED: all enables 0, halt=1. Only reset exits. Further halt_o3 or redirect is ignored.
- Simultaneous events:
  - mem_busy beats everything.
  - halt_o3 together with redirect_o3: the halt path wins.
  - Register 0 never triggers load_use.
- Reset asserted mid-stall or mid-drain: returns to RUN immediately; no partial state is kept.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined:
  - stall_cnt increments (saturating at all-ones) in each cycle in RUN where pc_en=0 or any pipe enable is 0.
  - Cleared on reset.
- Undefined: stall_cnt port is absent, and no counter logic exists.

Decomposition:
- diaosi_types_pkg gains:
  - hz_state_t enum {RUN, HALT_DRAIN, HALTED}
  - a hz_cause_t enum (MEMWAIT, HALT, REDIRECT, LOADUSE, IMISS, NONE) for waveform debug.
- regbits_t comes from cpu_types_pkg.
- One natural sub-module: hz_detect, a purely combinational block that computes load_use and mem_busy. The FSM and enable muxing stay in hazard_ctrl.

Test Plan:
- lw $1 in EX (d_ren_o2=1, wsel_o2=1), DEC rsel1_i2=1 -> one cycle with pc_en=0, pipe1_en=0, pipe2_en=1, hz_flushed2=1; next cycle all enables 1.
- Same pattern but wsel_o2=0 -> no stall, all enables 1.
- d_wen_o3=1, dhit=0 for 3 cycles -> all enables 0 for 3 cycles; on the dhit=1 cycle all enables 1.
- redirect_o3=1, ihit=0, load_use=1 -> pc_en=1, pipe1..4_en=1, hz_flushed1=hz_flushed2=flushed=1.
- halt_o3=1 with DRAIN_CYCLES=2 -> HALT_DRAIN for 2 cycles (pipe4_en=1, pc_en=0); halt rises on the following edge; afterwards redirect_o3=1 yields all enables 0.
- Pulse nRST low during HALT_DRAIN with a stall count of 5 -> state RUN, halt=0 and stall_cnt=0 immediately (async, before the next clock edge).

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : shared types for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      HALT_DRAIN = 2'd1,
      HALTED     = 2'd2
   } hz_state_t;

   // Winning RUN-state condition, kept as a named signal for waveform debug
   typedef enum logic [2:0] {
      MEMWAIT  = 3'd0,
      HALT     = 3'd1,
      REDIRECT = 3'd2,
      LOADUSE  = 3'd3,
      IMISS    = 3'd4,
      NONE     = 3'd5
   } hz_cause_t;

   function automatic logic reg_match(input regbits_t dst, input regbits_t src);
      return (dst != '0) && (dst == src);
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_detect.sv
// ============================================================================
// hz_detect : combinational load-use and data-memory-wait detection
// Rev 1.0
// ============================================================================
`default_nettype none

module hz_detect
   import hazard_ctrl_pkg::*;
(
   input  logic     d_ren_o2,
   input  regbits_t wsel_o2,
   input  regbits_t rsel1_i2,
   input  regbits_t rsel2_i2,
   input  logic     d_ren_o3,
   input  logic     d_wen_o3,
   input  logic     dhit,
   output logic     load_use,
   output logic     mem_busy
);

   assign mem_busy = (d_ren_o3 | d_wen_o3) & ~dhit;
   assign load_use = d_ren_o2 & (reg_match(wsel_o2, rsel1_i2) | reg_match(wsel_o2, rsel2_i2));

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : pipeline latch-enable/flush sequencing and halt drain FSM
// Optional stall counter enabled by macro HAZARD_STALL_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             d_ren_o2,
   input  logic [4:0]       wsel_o2,
   input  logic [4:0]       rsel1_i2,
   input  logic [4:0]       rsel2_i2,
   input  logic             d_ren_o3,
   input  logic             d_wen_o3,
   input  logic             redirect_o3,
   input  logic             halt_o3,
   output logic             pc_en,
   output logic             pipe1_en,
   output logic             pipe2_en,
   output logic             pipe3_en,
   output logic             pipe4_en,
   output logic             hz_flushed1,
   output logic             hz_flushed2,
   output logic             flushed,
   output logic             halt
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   hz_state_t          state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               halt_q, halt_d;
   hz_cause_t          cause;
   logic               load_use, mem_busy;
   logic [7:0]         ctl;

   hz_detect u_detect (
      .d_ren_o2 (d_ren_o2),
      .wsel_o2  (wsel_o2),
      .rsel1_i2 (rsel1_i2),
      .rsel2_i2 (rsel2_i2),
      .d_ren_o3 (d_ren_o3),
      .d_wen_o3 (d_wen_o3),
      .dhit     (dhit),
      .load_use (load_use),
      .mem_busy (mem_busy)
   );

   always_comb begin
      cause = NONE;
      if (mem_busy)         cause = MEMWAIT;
      else if (halt_o3)     cause = HALT;
      else if (redirect_o3) cause = REDIRECT;
      else if (load_use)    cause = LOADUSE;
      else if (!ihit)       cause = IMISS;
   end

   // ctl = {pc_en, pipe1..4_en, hz_flushed1, hz_flushed2, flushed}
   always_comb begin
      ctl     = 8'b00000_000;
      state_d = state_q;
      drain_d = drain_q;
      halt_d  = halt_q;
      unique case (state_q)
         RUN: begin
            unique case (cause)
               MEMWAIT:  ctl = 8'b00000_000;
               HALT: begin
                  ctl     = 8'b01111_111;
                  drain_d = '0;
                  state_d = HALT_DRAIN;
               end
               REDIRECT: ctl = 8'b11111_111;
               LOADUSE:  ctl = 8'b00111_010;
               IMISS:    ctl = 8'b01111_100;
               default:  ctl = 8'b11111_000;
            endcase
         end
         HALT_DRAIN: begin
            if (!mem_busy) begin
               ctl     = 8'b01111_111;
               drain_d = drain_q + DRAIN_W'(1);
               if (drain_q == DRAIN_LAST) begin
                  state_d = HALTED;
                  halt_d  = 1'b1;
               end
            end
         end
         HALTED: ctl = 8'b00000_000;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN;
         drain_q <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         halt_q  <= halt_d;
      end
   end

   // Latch controls are forced low for the whole reset window, not just at the edge
   assign {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
           hz_flushed1, hz_flushed2, flushed} = ctl & {8{nRST}};
   assign halt = halt_q;

`ifdef HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             stalled;

   assign stalled = (state_q == RUN) && (ctl[7:3] != 5'b11111);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stalled && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;
   import hazard_ctrl_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic       ihit, dhit, d_ren_o2, d_ren_o3, d_wen_o3, redirect_o3, halt_o3;
   logic [4:0] wsel_o2, rsel1_i2, rsel2_i2;
   logic       pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
   logic       hz_flushed1, hz_flushed2, flushed, halt;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_total = 0;
   int n_pass  = 0;

   always #5 CLK = ~CLK;

   hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .dhit        (dhit),
      .d_ren_o2    (d_ren_o2),
      .wsel_o2     (wsel_o2),
      .rsel1_i2    (rsel1_i2),
      .rsel2_i2    (rsel2_i2),
      .d_ren_o3    (d_ren_o3),
      .d_wen_o3    (d_wen_o3),
      .redirect_o3 (redirect_o3),
      .halt_o3     (halt_o3),
      .pc_en       (pc_en),
      .pipe1_en    (pipe1_en),
      .pipe2_en    (pipe2_en),
      .pipe3_en    (pipe3_en),
      .pipe4_en    (pipe4_en),
      .hz_flushed1 (hz_flushed1),
      .hz_flushed2 (hz_flushed2),
      .flushed     (flushed),
      .halt        (halt)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   // {halt, pc_en, pipe1..4_en, hz_flushed1, hz_flushed2, flushed}
   function automatic logic [8:0] obs();
      return {halt, pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
              hz_flushed1, hz_flushed2, flushed};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, got, exp);
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; d_ren_o2 = 1'b0; d_ren_o3 = 1'b0; d_wen_o3 = 1'b0;
      redirect_o3 = 1'b0; halt_o3 = 1'b0;
      wsel_o2 = 5'd0; rsel1_i2 = 5'd0; rsel2_i2 = 5'd0;
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      idle();
      nRST = 1'b0;
      #2;
      chk("reset_outputs", 32'(obs()), 32'b0_00000_000);
      chk("reset_state", 32'(dut.state_q), 32'(RUN));
      @(negedge CLK);
      nRST = 1'b1;

      next(); idle();
      @(negedge CLK); chk("run_idle", 32'(obs()), 32'b0_11111_000);

      next(); d_ren_o2 = 1'b1; wsel_o2 = 5'd1; rsel1_i2 = 5'd1;
      @(negedge CLK); chk("load_use_rs1", 32'(obs()), 32'b0_00111_010);
      next(); idle();
      @(negedge CLK); chk("after_load_use", 32'(obs()), 32'b0_11111_000);
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt_one", stall_cnt, 32'd1);
`endif

      next(); d_ren_o2 = 1'b1; wsel_o2 = 5'd0; rsel1_i2 = 5'd0;
      @(negedge CLK); chk("load_r0_no_stall", 32'(obs()), 32'b0_11111_000);

      next(); d_ren_o2 = 1'b1; wsel_o2 = 5'd7; rsel1_i2 = 5'd3; rsel2_i2 = 5'd7;
      @(negedge CLK); chk("load_use_rs2", 32'(obs()), 32'b0_00111_010);

      next(); idle(); d_wen_o3 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); chk("store_wait", 32'(obs()), 32'b0_00000_000);
         next();
      end
      dhit = 1'b1;
      @(negedge CLK); chk("store_dhit", 32'(obs()), 32'b0_11111_000);

      next(); idle(); redirect_o3 = 1'b1; ihit = 1'b0;
      d_ren_o2 = 1'b1; wsel_o2 = 5'd4; rsel1_i2 = 5'd4;
      @(negedge CLK); chk("redirect_over_all", 32'(obs()), 32'b0_11111_111);

      next(); idle(); ihit = 1'b0;
      @(negedge CLK); chk("imiss", 32'(obs()), 32'b0_01111_100);

      next(); idle(); d_ren_o3 = 1'b1; halt_o3 = 1'b1; redirect_o3 = 1'b1;
      @(negedge CLK); chk("membusy_beats_halt", 32'(obs()), 32'b0_00000_000);

      next(); idle(); halt_o3 = 1'b1; redirect_o3 = 1'b1;
      @(negedge CLK); chk("halt_enter", 32'(obs()), 32'b0_01111_111);
      next(); idle();
      @(negedge CLK); chk("drain_1", 32'(obs()), 32'b0_01111_111);
      chk("drain_state", 32'(dut.state_q), 32'(HALT_DRAIN));
      next();
      @(negedge CLK); chk("drain_2", 32'(obs()), 32'b0_01111_111);
      next(); redirect_o3 = 1'b1; halt_o3 = 1'b1;
      @(negedge CLK); chk("halted", 32'(obs()), 32'b1_00000_000);
      next();
      @(negedge CLK); chk("halted_hold", 32'(obs()), 32'b1_00000_000);

      nRST = 1'b0;
      #1;
      chk("async_rst_halted", 32'(obs()), 32'b0_00000_000);
      chk("async_rst_state", 32'(dut.state_q), 32'(RUN));
      @(negedge CLK); nRST = 1'b1; idle();
      @(negedge CLK); chk("run_after_rst", 32'(obs()), 32'b0_11111_000);

      // Second drain: a data wait freezes the drain and its counter
      next(); halt_o3 = 1'b1;
      @(negedge CLK); chk("halt_enter2", 32'(obs()), 32'b0_01111_111);
      next(); idle(); d_ren_o3 = 1'b1;
      @(negedge CLK); chk("drain_frozen", 32'(obs()), 32'b0_00000_000);
      next(); idle();
      @(negedge CLK); chk("drain_after_freeze1", 32'(obs()), 32'b0_01111_111);
      next();
      @(negedge CLK); chk("drain_after_freeze2", 32'(obs()), 32'b0_01111_111);
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt_nonzero", 32'(stall_cnt != 32'd0), 32'd1);
`endif
      nRST = 1'b0;
      #1;
      chk("async_rst_drain", 32'(obs()), 32'b0_00000_000);
      chk("async_rst_drain_state", 32'(dut.state_q), 32'(RUN));
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt_cleared", stall_cnt, 32'd0);
`endif
      @(negedge CLK); nRST = 1'b1;
      next();
      @(negedge CLK); chk("run_final", 32'(obs()), 32'b0_11111_000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
